// File: rtl/mips_run_monitor.sv
// Run monitor for a multi-cycle MIPS datapath: counts cycles and fetches, then
// reports halt (repeated fetch PC), fault (Error) or timeout as a sticky verdict.
module mips_run_monitor #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned FETCH_STATE = 0,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned HALT_REPEAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic [STATE_W-1:0] state,
    input  logic [DATA_W-1:0]  PC_out,
    input  logic [DATA_W-1:0]  instr,
    input  logic               Error,
    output logic [2:0]         mon_state,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count,
    output logic [DATA_W-1:0]  last_pc,
    output logic [DATA_W-1:0]  last_instr,
    output logic               done,
    output logic               pass
);

    localparam int unsigned REP_W = 5;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StHalted  = 3'd2,
        StFault   = 3'd3,
        StTimeout = 3'd4
    } mon_state_e;

    localparam logic [STATE_W-1:0] FetchSt  = STATE_W'(FETCH_STATE);
    localparam logic [CNT_W-1:0]   CycLast  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [REP_W-1:0]   HaltRep  = REP_W'(HALT_REPEAT);

    mon_state_e          mon_q, mon_d;
    logic [CNT_W-1:0]    cycle_q, instr_cnt_q;
    logic [CNT_W-1:0]    cycle_inc, instr_inc;
    logic [DATA_W-1:0]   last_pc_q, last_instr_q;
    logic [STATE_W-1:0]  prev_state_q;
    logic [REP_W-1:0]    rep_q, rep_inc;
    logic                pend_q, done_q, pass_q;
    logic                fetch, pc_match;

    always_comb begin
        fetch     = (mon_q == StRun) && (state == FetchSt) && (prev_state_q != FetchSt);
        pc_match  = (PC_out == last_pc_q) && (instr_cnt_q != '0);
        cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        instr_inc = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + 1'b1;
        rep_inc   = (rep_q == '1) ? rep_q : rep_q + 1'b1;
    end

    // Exit priority: FAULT > HALTED > TIMEOUT.
    always_comb begin
        mon_d = mon_q;
        unique case (mon_q)
            StIdle: if (start) mon_d = StRun;
            StRun: begin
                if (Error)                  mon_d = StFault;
                else if (rep_q >= HaltRep)  mon_d = StHalted;
                else if (cycle_q == CycLast) mon_d = StTimeout;
            end
            StHalted, StFault, StTimeout: if (clear) mon_d = StIdle;
            default: mon_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_q        <= StIdle;
            cycle_q      <= '0;
            instr_cnt_q  <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
            prev_state_q <= FetchSt;
            rep_q        <= '0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            mon_q        <= mon_d;
            done_q       <= (mon_d == StHalted) || (mon_d == StFault) || (mon_d == StTimeout);
            pass_q       <= (mon_d == StHalted);
            prev_state_q <= state;
            if ((mon_q == StIdle) && start) begin
                cycle_q      <= '0;
                instr_cnt_q  <= '0;
                last_pc_q    <= '0;
                last_instr_q <= '0;
                rep_q        <= '0;
                pend_q       <= 1'b0;
                prev_state_q <= FetchSt;
            end else if (mon_q == StRun) begin
                cycle_q <= cycle_inc;
                // instr is captured in the cycle following the fetch.
                pend_q  <= fetch;
                if (pend_q) last_instr_q <= instr;
                if (fetch) begin
                    instr_cnt_q <= instr_inc;
                    last_pc_q   <= PC_out;
                    rep_q       <= pc_match ? rep_inc : '0;
                end
            end
        end
    end

    assign mon_state   = mon_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_cnt_q;
    assign last_pc     = last_pc_q;
    assign last_instr  = last_instr_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: a vector table for the halt program plus
// hand sequences for fault, simultaneous exits, timeout and mid-run reset.
module tb_mips_run_monitor;

    localparam logic [31:0] IB = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, clear = 1'b0, err = 1'b0;
    logic [3:0]  st = '0;
    logic [31:0] pc = '0, ins = '0;

    logic [2:0]  d_mon, t_mon;
    logic [31:0] d_cc, d_ic, d_lpc, d_li, t_cc, t_ic, t_lpc, t_li;
    logic        d_done, d_pass, t_done, t_pass;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    mips_run_monitor u_dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .state(st), .PC_out(pc),
        .instr(ins), .Error(err), .mon_state(d_mon), .cycle_count(d_cc), .instr_count(d_ic),
        .last_pc(d_lpc), .last_instr(d_li), .done(d_done), .pass(d_pass)
    );

    mips_run_monitor #(.TIMEOUT_CYC(20)) u_to (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .state(st), .PC_out(pc),
        .instr(ins), .Error(err), .mon_state(t_mon), .cycle_count(t_cc), .instr_count(t_ic),
        .last_pc(t_lpc), .last_instr(t_li), .done(t_done), .pass(t_pass)
    );

    typedef struct {
        logic        r, s, c, e;
        logic [3:0]  st;
        logic [31:0] pc;
        logic [2:0]  mon;
        logic [31:0] cc, ic, lpc, li;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic c, logic [3:0] vst, logic [31:0] vpc,
                                logic e, logic [2:0] mon, logic [31:0] cc, logic [31:0] ic,
                                logic [31:0] lpc, logic [31:0] li);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.st = vst; v.pc = vpc; v.e = e;
        v.mon = mon; v.cc = cc; v.ic = ic; v.lpc = lpc; v.li = li;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic r, input logic s, input logic c, input logic [3:0] vst,
                       input logic [31:0] vpc, input logic e);
        rst = r; start = s; clear = c; st = vst; pc = vpc; ins = IB | vpc; err = e;
        @(posedge clk);
        #1;
    endtask

    // Halt program: one lead-in state 3, then fetches at PC 0,4,8,8,8 (states 0..3).
    function automatic logic [3:0] st_h(int k);
        return 4'((k + 2) % 4);
    endfunction

    function automatic logic [31:0] pc_h(int k);
        int j;
        if (k < 2) return 32'd0;
        j = (k - 2) / 4;
        if (j > 2) j = 2;
        return 32'(j * 4);
    endfunction

    initial begin
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));        // reset
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0));        // clear ignored in IDLE
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 1,  0, 0, 0, 0));        // start
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 1,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 0));        // fetch #1 PC 0
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1,  3, 1, 0, IB));
        vecs.push_back(mk(0, 0, 0, 2, 0, 0, 1,  4, 1, 0, IB));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 1,  5, 1, 0, IB));
        vecs.push_back(mk(0, 0, 0, 0, 4, 0, 1,  6, 2, 4, IB));       // fetch #2 PC 4
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 1,  7, 2, 4, IB | 4));
        vecs.push_back(mk(0, 0, 0, 2, 4, 0, 1,  8, 2, 4, IB | 4));
        vecs.push_back(mk(0, 0, 0, 3, 4, 0, 1,  9, 2, 4, IB | 4));
        vecs.push_back(mk(0, 0, 0, 0, 8, 0, 1, 10, 3, 8, IB | 4));   // fetch #3 PC 8
        vecs.push_back(mk(0, 0, 0, 1, 8, 0, 1, 11, 3, 8, IB | 8));
        vecs.push_back(mk(0, 0, 0, 2, 8, 0, 1, 12, 3, 8, IB | 8));
        vecs.push_back(mk(0, 0, 0, 3, 8, 0, 1, 13, 3, 8, IB | 8));
        vecs.push_back(mk(0, 0, 0, 0, 8, 0, 1, 14, 4, 8, IB | 8));   // repeat 1
        vecs.push_back(mk(0, 0, 0, 1, 8, 0, 1, 15, 4, 8, IB | 8));
        vecs.push_back(mk(0, 0, 0, 2, 8, 0, 1, 16, 4, 8, IB | 8));
        vecs.push_back(mk(0, 0, 0, 3, 8, 0, 1, 17, 4, 8, IB | 8));
        vecs.push_back(mk(0, 0, 0, 0, 8, 0, 1, 18, 5, 8, IB | 8));   // repeat 2
        vecs.push_back(mk(0, 0, 0, 1, 8, 0, 2, 19, 5, 8, IB | 8));   // HALTED
        vecs.push_back(mk(0, 0, 0, 2, 8, 0, 2, 19, 5, 8, IB | 8));   // sticky
        vecs.push_back(mk(0, 1, 0, 3, 8, 0, 2, 19, 5, 8, IB | 8));   // start ignored
        vecs.push_back(mk(0, 1, 1, 3, 8, 0, 0, 19, 5, 8, IB | 8));   // clear wins in HALTED
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 1,  0, 0, 0, 0));        // restart clears
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 1,  1, 0, 0, 0));        // clear ignored in RUN
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1,  2, 1, 0, 0));        // start ignored in RUN
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));        // rst beats start

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            cyc(v.r, v.s, v.c, v.st, v.pc, v.e);
            chk($sformatf("vec%0d.mon_state", i), 32'(d_mon), 32'(v.mon));
            chk($sformatf("vec%0d.cycle_count", i), d_cc, v.cc);
            chk($sformatf("vec%0d.instr_count", i), d_ic, v.ic);
            chk($sformatf("vec%0d.last_pc", i), d_lpc, v.lpc);
            chk($sformatf("vec%0d.last_instr", i), d_li, v.li);
            chk($sformatf("vec%0d.done", i), 32'(d_done), 32'(v.mon >= 3'd2));
            chk($sformatf("vec%0d.pass", i), 32'(d_pass), 32'(v.mon == 3'd2));
        end

        // Error on RUN cycle 7 -> FAULT, cycle_count 7, then held.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 7; k++) cyc(0, 0, 0, st_h(k), pc_h(k), k == 7);
        chk("fault.mon_state", 32'(d_mon), 32'd3);
        chk("fault.cycle_count", d_cc, 32'd7);
        chk("fault.instr_count", d_ic, 32'd2);
        chk("fault.done", 32'(d_done), 32'd1);
        chk("fault.pass", 32'(d_pass), 32'd0);
        cyc(0, 0, 0, st_h(8), pc_h(8), 0);
        chk("fault_hold.mon_state", 32'(d_mon), 32'd3);
        chk("fault_hold.cycle_count", d_cc, 32'd7);
        cyc(0, 0, 1, 0, 0, 0);
        chk("fault_clear.mon_state", 32'(d_mon), 32'd0);
        chk("fault_clear.cycle_count", d_cc, 32'd7);

        // Error coincides with the halt condition -> FAULT.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 18; k++) cyc(0, 0, 0, st_h(k), pc_h(k), 0);
        chk("both_pre.mon_state", 32'(d_mon), 32'd1);
        cyc(0, 0, 0, st_h(19), pc_h(19), 1);
        chk("both.mon_state", 32'(d_mon), 32'd3);
        chk("both.pass", 32'(d_pass), 32'd0);
        chk("both.done", 32'(d_done), 32'd1);

        // Mid-RUN reset at cycle 10, then a fresh run counts from 0.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 9; k++) cyc(0, 0, 0, st_h(k), pc_h(k), 0);
        chk("midrun.cycle_count", d_cc, 32'd9);
        chk("midrun.instr_count", d_ic, 32'd2);
        chk("midrun.last_pc", d_lpc, 32'd4);
        chk("midrun.last_instr", d_li, IB | 32'd4);
        cyc(1, 0, 0, st_h(10), pc_h(10), 0);
        chk("rst.mon_state", 32'(d_mon), 32'd0);
        chk("rst.cycle_count", d_cc, 32'd0);
        chk("rst.instr_count", d_ic, 32'd0);
        chk("rst.last_pc", d_lpc, 32'd0);
        chk("rst.last_instr", d_li, 32'd0);
        chk("rst.done", 32'(d_done), 32'd0);
        cyc(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 3; k++) cyc(0, 0, 0, st_h(k), pc_h(k), 0);
        chk("rerun.mon_state", 32'(d_mon), 32'd1);
        chk("rerun.cycle_count", d_cc, 32'd3);
        chk("rerun.instr_count", d_ic, 32'd1);
        chk("rerun.last_instr", d_li, IB);

        // Timeout instance (TIMEOUT_CYC=20) with the PC always advancing.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 19; k++) cyc(0, 0, 0, 4'((k + 1) % 4), 32'(4 * k), 0);
        chk("to_pre.mon_state", 32'(t_mon), 32'd1);
        chk("to_pre.cycle_count", t_cc, 32'd19);
        cyc(0, 0, 0, 4'(21 % 4), 32'd80, 0);
        chk("to.mon_state", 32'(t_mon), 32'd4);
        chk("to.cycle_count", t_cc, 32'd20);
        chk("to.instr_count", t_ic, 32'd5);
        chk("to.last_pc", t_lpc, 32'd76);
        chk("to.last_instr", t_li, IB | 32'd80);
        chk("to.done", 32'(t_done), 32'd1);
        chk("to.pass", 32'(t_pass), 32'd0);
        cyc(0, 0, 0, 2, 84, 0);
        chk("to_hold.cycle_count", t_cc, 32'd20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_run_monitor.md
MIPS_RUN_MONITOR -- requirements
Module: mips_run_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of PC and instruction buses.
REQ-002 SHALL have parameter STATE_W, default 4, meaning width of the datapath control-state bus.
REQ-003 SHALL have parameter FETCH_STATE, default 0, meaning the state encoding that marks the start of an instruction.
REQ-004 SHALL have parameter CNT_W, default 32, meaning width of the cycle and instruction counters.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000, meaning the cycle budget before a timeout verdict.
REQ-006 SHALL have parameter HALT_REPEAT, default 2, meaning the number of consecutive fetches at the same PC that count as a halt (range 1..15).
REQ-007 SHALL have port clk, input, 1, meaning system clock, with all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, meaning a one-cycle pulse that begins monitoring.
REQ-010 SHALL have port clear, input, 1, meaning a one-cycle pulse that returns the monitor from a terminal state to IDLE.
REQ-011 SHALL have port state, input, STATE_W, meaning the datapath control state.
REQ-012 SHALL have port PC_out, input, DATA_W, meaning the datapath program counter.
REQ-013 SHALL have port instr, input, DATA_W, meaning the current instruction register.
REQ-014 SHALL have port Error, input, 1, meaning the datapath error flag.
REQ-015 SHALL have port mon_state, output, 3, meaning encoding IDLE=0, RUN=1, HALTED=2, FAULT=3, TIMEOUT=4.
REQ-016 SHALL have port cycle_count, output, CNT_W, meaning the number of cycles spent in RUN.
REQ-017 SHALL have port instr_count, output, CNT_W, meaning the number of retired fetches.
REQ-018 SHALL have port last_pc, output, DATA_W, meaning the PC captured at the most recent fetch.
REQ-019 SHALL have port last_instr, output, DATA_W, meaning the instr value captured one cycle after the most recent fetch.
REQ-020 SHALL have port done, output, 1, meaning high in HALTED, FAULT or TIMEOUT.
REQ-021 SHALL have port pass, output, 1, meaning high only in HALTED.

Function
REQ-022 SHALL move IDLE->RUN on start; start SHALL be ignored outside IDLE.
REQ-023 SHALL clear cycle_count, instr_count, the repeat counter, last_pc and last_instr on the IDLE->RUN edge.
REQ-024 SHALL increment cycle_count by 1 every RUN cycle, saturating at all-ones.
REQ-025 SHALL register state as prev_state, which resets to FETCH_STATE and is reloaded with FETCH_STATE on the IDLE->RUN edge.
REQ-026 SHALL define a fetch event as a RUN cycle with state==FETCH_STATE and prev_state!=FETCH_STATE, so the first fetch counts on the first re-entry to fetch.
REQ-027 SHALL, on each fetch event, increment instr_count (saturating), capture PC_out into last_pc, and capture instr into last_instr one cycle later.
REQ-028 SHALL, on a fetch event with PC_out==last_pc and instr_count>0, increment the repeat counter; otherwise the repeat counter SHALL reset to 0.
REQ-029 SHALL move RUN->HALTED in the cycle after the repeat counter reaches HALT_REPEAT.
REQ-030 SHALL move RUN->FAULT in the cycle after Error is sampled high in RUN.
REQ-031 SHALL move RUN->TIMEOUT when cycle_count==TIMEOUT_CYC-1 is sampled in RUN.
REQ-032 SHALL resolve simultaneous exit conditions with priority FAULT > HALTED > TIMEOUT.
REQ-033 SHALL hold all counters and captures in terminal states; the states are sticky until clear or rst.
REQ-034 SHALL move a terminal state to IDLE on clear with counters held, and SHALL ignore clear in IDLE and RUN.
REQ-035 SHALL take start and clear only in their own states when both are high in the same cycle, so the two never conflict.
REQ-036 SHALL drive done and pass as registered decodes of mon_state with no combinational path from inputs.

Reset
REQ-037 SHALL, when rst is high at a clock edge, force mon_state=IDLE and every counter, capture, done and pass to 0, regardless of the current state, including mid-RUN.
REQ-038 SHALL give rst priority over start, clear and all transitions.

Verification
REQ-039 SHALL check: rst, then start, then state cycling 0,1,2,3,0 with PC 0,4,8 then 8,8 -> HALTED, pass=1, last_pc=8, instr_count=5.
REQ-040 SHALL check: Error pulsed high on RUN cycle 7 -> FAULT at cycle 8, pass=0, done=1, cycle_count=7.
REQ-041 SHALL check: TIMEOUT_CYC=20 with the PC always advancing -> TIMEOUT with cycle_count=20, pass=0.
REQ-042 SHALL check: Error and the halt condition on the same cycle -> FAULT.
REQ-043 SHALL check: rst asserted mid-RUN at cycle 10 -> next cycle mon_state=0 and all counters 0; a subsequent start counts from 0.
REQ-044 SHALL check: clear in HALTED -> IDLE with counters held; a second start clears the counters.
